dsp_issue_ctrl: RTL and testbench

DSP_ISSUE_CTRL -- requirements
Module: dsp_issue_ctrl

---
 rtl/dsp_issue_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_dsp_issue_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_issue_ctrl.sv
// Issue controller that sequences one request into a multi-beat DSP datapath and returns its result.
// Optional macro DSP_ISSUE_OVERLAP_EN: accept the next request in the cycle the response retires.
module dsp_issue_ctrl #(
   parameter int N       = 16,
   parameter int M       = 16,
   parameter int RES_LAT = 0
) (
   input  logic             clk,
   input  logic             reset,

   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_mode,
   input  logic [N-1:0]     req_a,
   input  logic [M-1:0]     req_b,
   input  logic [N+M-1:0]   req_c,
   input  logic             req_mac,
   input  logic [1:0]       req_shift_amount,
   input  logic             req_shift_dir,

   output logic             dsp_start,
   output logic             dsp_mac,
   output logic             dsp_mac_start,
   output logic             dsp_shift_dir,
   output logic [1:0]       dsp_mode,
   output logic [1:0]       dsp_shift_amount,
   output logic [1:0]       dsp_pipe_stages,
   output logic [N-1:0]     dsp_aa,
   output logic [M-1:0]     dsp_bb,
   output logic [N+M-1:0]   dsp_cc,
   input  logic [N+M-1:0]   dsp_out,

   output logic             rsp_valid,
   output logic [N+M-1:0]   rsp_data,
   output logic             rsp_err,
   input  logic             rsp_ready
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [1:0] MODE_ILLEGAL = 2'd3;
   localparam logic [1:0] WAIT_LAST    = (RES_LAT > 0) ? 2'(RES_LAT - 1) : 2'd0;

   logic [1:0]     state;
   logic [1:0]     beat_cnt;
   logic [1:0]     wait_cnt;
   logic [1:0]     last_beat;
   logic           prev_mac;
   logic           mac_start_q;

   logic [1:0]     mode_q;
   logic [N-1:0]   a_q;
   logic [M-1:0]   b_q;
   logic [N+M-1:0] c_q;
   logic           mac_q;
   logic [1:0]     shamt_q;
   logic           shdir_q;

   logic [N+M-1:0] rsp_data_q;
   logic           rsp_err_q;

   logic           accept;
   logic           issuing;
   logic           beat_done;

   // Beat count minus one: mode 0 -> 1 beat, mode 1 -> 2 beats, mode 2 -> 4 beats.
   function automatic logic [1:0] beats_m1(input logic [1:0] mode);
      case (mode)
         2'd0:    beats_m1 = 2'd0;
         2'd1:    beats_m1 = 2'd1;
         default: beats_m1 = 2'd3;
      endcase
   endfunction

`ifdef DSP_ISSUE_OVERLAP_EN
   assign req_ready = (state == S_IDLE) || ((state == S_RESP) && rsp_ready);
`else
   assign req_ready = (state == S_IDLE);
`endif

   assign accept    = req_valid && req_ready;
   assign issuing   = (state == S_ISSUE);
   assign beat_done = (beat_cnt == last_beat);

   // NOTE: request fields are not reset; every output they feed is gated by
   // the FSM state, so their contents are never visible outside ISSUE.
   always_ff @(posedge clk) begin
      if (accept) begin
         mode_q    <= req_mode;
         a_q       <= req_a;
         b_q       <= req_b;
         c_q       <= req_c;
         mac_q     <= req_mac;
         shamt_q   <= req_shift_amount;
         shdir_q   <= req_shift_dir;
         last_beat <= beats_m1(req_mode);
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         beat_cnt    <= 2'd0;
         wait_cnt    <= 2'd0;
         prev_mac    <= 1'b0;
         mac_start_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else if (accept) begin
         // Reached from IDLE, or from RESP when the response retires this cycle.
         beat_cnt <= 2'd0;
         wait_cnt <= 2'd0;
         if (req_mode == MODE_ILLEGAL) begin
            state      <= S_RESP;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
         end else begin
            state       <= S_ISSUE;
            mac_start_q <= req_mac && !prev_mac;
            prev_mac    <= req_mac;
         end
      end else begin
         case (state)
            S_ISSUE: begin
               if (beat_done) begin
                  beat_cnt <= 2'd0;
                  if (RES_LAT == 0) begin
                     state      <= S_RESP;
                     rsp_data_q <= dsp_out;
                     rsp_err_q  <= 1'b0;
                  end else begin
                     state    <= S_WAIT;
                     wait_cnt <= 2'd0;
                  end
               end else begin
                  beat_cnt <= beat_cnt + 2'd1;
               end
            end
            S_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  wait_cnt   <= 2'd0;
                  state      <= S_RESP;
                  rsp_data_q <= dsp_out;
                  rsp_err_q  <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // NOTE: datapath drive is purely combinational with every output assigned
   // on every path, so no latch can be inferred.
   always_comb begin
      dsp_start        = 1'b0;
      dsp_mac          = 1'b0;
      dsp_mac_start    = 1'b0;
      dsp_mode         = 2'd0;
      dsp_shift_amount = 2'd0;
      dsp_shift_dir    = 1'b0;
      dsp_aa           = '0;
      dsp_bb           = '0;
      dsp_cc           = '0;
      if (issuing) begin
         dsp_start        = (beat_cnt == 2'd0);
         dsp_mac          = mac_q;
         dsp_mac_start    = (beat_cnt == 2'd0) && mac_start_q;
         dsp_mode         = mode_q;
         dsp_shift_amount = shamt_q;
         dsp_shift_dir    = shdir_q;
         dsp_aa           = a_q;
         dsp_bb           = b_q;
         dsp_cc           = c_q;
      end
   end

   assign dsp_pipe_stages = 2'd0;

   assign rsp_valid = (state == S_RESP);
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dsp_issue_ctrl.sv
// Directed testbench for dsp_issue_ctrl (default RES_LAT=0); DSP datapath is a stub driven by the bench.
module tb_dsp_issue_ctrl;

   localparam int N = 16;
   localparam int M = 16;
   localparam int W = N + M;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_mode;
   logic [N-1:0]  req_a;
   logic [M-1:0]  req_b;
   logic [W-1:0]  req_c;
   logic          req_mac;
   logic [1:0]    req_shift_amount;
   logic          req_shift_dir;
   logic          dsp_start;
   logic          dsp_mac;
   logic          dsp_mac_start;
   logic          dsp_shift_dir;
   logic [1:0]    dsp_mode;
   logic [1:0]    dsp_shift_amount;
   logic [1:0]    dsp_pipe_stages;
   logic [N-1:0]  dsp_aa;
   logic [M-1:0]  dsp_bb;
   logic [W-1:0]  dsp_cc;
   logic [W-1:0]  dsp_out;
   logic          rsp_valid;
   logic [W-1:0]  rsp_data;
   logic          rsp_err;
   logic          rsp_ready;

   int vectors = 0;
   int miscompares = 0;

   dsp_issue_ctrl #(.N(N), .M(M), .RES_LAT(0)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
      .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_mac(req_mac),
      .req_shift_amount(req_shift_amount), .req_shift_dir(req_shift_dir),
      .dsp_start(dsp_start), .dsp_mac(dsp_mac), .dsp_mac_start(dsp_mac_start),
      .dsp_shift_dir(dsp_shift_dir), .dsp_mode(dsp_mode),
      .dsp_shift_amount(dsp_shift_amount), .dsp_pipe_stages(dsp_pipe_stages),
      .dsp_aa(dsp_aa), .dsp_bb(dsp_bb), .dsp_cc(dsp_cc), .dsp_out(dsp_out),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .rsp_ready(rsp_ready)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge, where outputs are settled.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request in the current cycle; returns one cycle later (cycle 1).
   task automatic send(input logic [1:0] mode, input logic [N-1:0] a, input logic [M-1:0] b,
                       input logic [W-1:0] c, input logic mac, input logic [1:0] shamt,
                       input logic dir);
      req_mode = mode; req_a = a; req_b = b; req_c = c;
      req_mac = mac; req_shift_amount = shamt; req_shift_dir = dir;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      vectors++;
      if ({rsp_valid, rsp_err, dsp_start, dsp_mac} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_flags: got %b want 0000", {rsp_valid, rsp_err, dsp_start, dsp_mac});
      end
      vectors++;
      if (rsp_data !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_rsp_data: got %h want 00000000", rsp_data);
      end
      reset = 1'b0;
      step();
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_req_ready: got %b want 1", req_ready);
      end
   endtask

   task automatic test_mode0();
      rsp_ready = 1'b1;
      dsp_out   = 32'h0000_000F;
      send(2'd0, 16'h0003, 16'h0005, 32'h0, 1'b0, 2'd0, 1'b0);
      vectors++;
      if ({dsp_start, rsp_valid, req_ready} !== 3'b100) begin
         miscompares++;
         $display("FAIL m0_c1_ctrl: got %b want 100", {dsp_start, rsp_valid, req_ready});
      end
      vectors++;
      if ({dsp_aa, dsp_bb} !== {16'h0003, 16'h0005}) begin
         miscompares++;
         $display("FAIL m0_c1_operands: got %h want 00030005", {dsp_aa, dsp_bb});
      end
      step();
      vectors++;
      if ({dsp_start, rsp_valid, rsp_err} !== 3'b010) begin
         miscompares++;
         $display("FAIL m0_c2_ctrl: got %b want 010", {dsp_start, rsp_valid, rsp_err});
      end
      vectors++;
      if (rsp_data !== 32'h0000_000F) begin
         miscompares++;
         $display("FAIL m0_c2_data: got %h want 0000000f", rsp_data);
      end
      vectors++;
      if ({dsp_aa, dsp_bb} !== 32'h0) begin
         miscompares++;
         $display("FAIL m0_c2_zeroed: got %h want 00000000", {dsp_aa, dsp_bb});
      end
      step();
      vectors++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL m0_c3_idle: got %b want 01", {rsp_valid, req_ready});
      end
   endtask

   task automatic test_mode2();
      rsp_ready = 1'b1;
      send(2'd2, 16'hFFFF, 16'h0002, 32'h1234_5678, 1'b0, 2'd2, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         dsp_out = 32'h1000_0000 + 32'(k);
         vectors++;
         if (dsp_start !== (k == 1)) begin
            miscompares++;
            $display("FAIL m2_start_c%0d: got %b want %b", k, dsp_start, (k == 1));
         end
         vectors++;
         if ({dsp_aa, dsp_bb, dsp_cc} !== {16'hFFFF, 16'h0002, 32'h1234_5678}) begin
            miscompares++;
            $display("FAIL m2_operands_c%0d: got %h want ffff000212345678", k, {dsp_aa, dsp_bb, dsp_cc});
         end
         vectors++;
         if ({dsp_mode, dsp_shift_amount, dsp_shift_dir, dsp_pipe_stages, rsp_valid} !== 8'b10_10_1_00_0) begin
            miscompares++;
            $display("FAIL m2_fields_c%0d: got %b want 10101000", k,
                     {dsp_mode, dsp_shift_amount, dsp_shift_dir, dsp_pipe_stages, rsp_valid});
         end
         step();
      end
      dsp_out = 32'hDEAD_BEEF;
      vectors++;
      if ({rsp_valid, rsp_err, dsp_start} !== 3'b100) begin
         miscompares++;
         $display("FAIL m2_c5_ctrl: got %b want 100", {rsp_valid, rsp_err, dsp_start});
      end
      vectors++;
      if (rsp_data !== 32'h1000_0004) begin
         miscompares++;
         $display("FAIL m2_c5_data: got %h want 10000004", rsp_data);
      end
      step();
   endtask

   task automatic test_mode3();
      rsp_ready = 1'b1;
      dsp_out   = 32'h0000_0055;
      send(2'd3, 16'h00AA, 16'h00BB, 32'h1, 1'b0, 2'd0, 1'b0);
      vectors++;
      if ({dsp_start, rsp_valid, rsp_err} !== 3'b011) begin
         miscompares++;
         $display("FAIL m3_c1_ctrl: got %b want 011", {dsp_start, rsp_valid, rsp_err});
      end
      vectors++;
      if (rsp_data !== 32'h0) begin
         miscompares++;
         $display("FAIL m3_c1_data: got %h want 00000000", rsp_data);
      end
      step();
      vectors++;
      if ({dsp_start, rsp_valid, req_ready} !== 3'b001) begin
         miscompares++;
         $display("FAIL m3_c2_idle: got %b want 001", {dsp_start, rsp_valid, req_ready});
      end
   endtask

   task automatic test_stall();
      rsp_ready = 1'b0;
      dsp_out   = 32'h0000_003F;
      send(2'd0, 16'h0007, 16'h0009, 32'h0, 1'b0, 2'd0, 1'b0);
      step();
      dsp_out = 32'h0000_0BAD;
      req_mode = 2'd1; req_a = 16'h1111; req_b = 16'h2222; req_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if ({rsp_valid, rsp_err, req_ready, dsp_start} !== 4'b1000) begin
            miscompares++;
            $display("FAIL stall_ctrl_%0d: got %b want 1000", k, {rsp_valid, rsp_err, req_ready, dsp_start});
         end
         vectors++;
         if (rsp_data !== 32'h0000_003F) begin
            miscompares++;
            $display("FAIL stall_data_%0d: got %h want 0000003f", k, rsp_data);
         end
         step();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      vectors++;
      if ({rsp_valid, dsp_start, req_ready} !== 3'b001) begin
         miscompares++;
         $display("FAIL stall_release: got %b want 001", {rsp_valid, dsp_start, req_ready});
      end
   endtask

   task automatic test_reset_midflight();
      rsp_ready = 1'b1;
      dsp_out   = 32'h0000_0077;
      send(2'd2, 16'hFFFF, 16'h0002, 32'h0000_00FF, 1'b1, 2'd1, 1'b1);
      step();
      reset = 1'b1;
      step();
      vectors++;
      if ({rsp_valid, rsp_err, req_ready, dsp_start, dsp_mac, dsp_mac_start, dsp_shift_dir} !== 7'b0010000) begin
         miscompares++;
         $display("FAIL rst_mid_flags: got %b want 0010000",
                  {rsp_valid, rsp_err, req_ready, dsp_start, dsp_mac, dsp_mac_start, dsp_shift_dir});
      end
      vectors++;
      if ({dsp_aa, dsp_bb, dsp_cc, rsp_data, dsp_mode, dsp_shift_amount, dsp_pipe_stages} !== 102'h0) begin
         miscompares++;
         $display("FAIL rst_mid_buses: got %h want 0",
                  {dsp_aa, dsp_bb, dsp_cc, rsp_data, dsp_mode, dsp_shift_amount, dsp_pipe_stages});
      end
      reset = 1'b0;
      step();
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid_ready: got %b want 1", req_ready);
      end
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if ({rsp_valid, dsp_start} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_mid_quiet_%0d: got %b want 00", k, {rsp_valid, dsp_start});
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      rsp_ready = 1'b1;
      dsp_out   = 32'h0000_0100;
      // Mac history was cleared by the previous reset, so this first mac request starts fresh.
      send(2'd0, 16'h0010, 16'h0020, 32'h0, 1'b1, 2'd0, 1'b0);
      vectors++;
      if ({dsp_start, dsp_mac, dsp_mac_start} !== 3'b111) begin
         miscompares++;
         $display("FAIL b2b_first_beat: got %b want 111", {dsp_start, dsp_mac, dsp_mac_start});
      end
      step();
      req_mode = 2'd1; req_a = 16'h0030; req_b = 16'h0040; req_c = 32'h0;
      req_mac = 1'b1; req_valid = 1'b1;
`ifdef DSP_ISSUE_OVERLAP_EN
      vectors++;
      if ({rsp_valid, req_ready} !== 2'b11) begin
         miscompares++;
         $display("FAIL b2b_overlap_ready: got %b want 11", {rsp_valid, req_ready});
      end
      step();
`else
      vectors++;
      if ({rsp_valid, req_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL b2b_resp_ready: got %b want 10", {rsp_valid, req_ready});
      end
      step();
      vectors++;
      if ({rsp_valid, req_ready, dsp_start} !== 3'b010) begin
         miscompares++;
         $display("FAIL b2b_idle_gap: got %b want 010", {rsp_valid, req_ready, dsp_start});
      end
      step();
`endif
      req_valid = 1'b0;
      dsp_out   = 32'h0000_0200;
      vectors++;
      if ({dsp_start, dsp_mac, dsp_mac_start} !== 3'b110) begin
         miscompares++;
         $display("FAIL b2b_second_beat1: got %b want 110", {dsp_start, dsp_mac, dsp_mac_start});
      end
      vectors++;
      if ({dsp_aa, dsp_bb, dsp_mode} !== {16'h0030, 16'h0040, 2'd1}) begin
         miscompares++;
         $display("FAIL b2b_second_operands: got %h want %h", {dsp_aa, dsp_bb, dsp_mode}, {16'h0030, 16'h0040, 2'd1});
      end
      step();
      vectors++;
      if ({dsp_start, dsp_mac, dsp_mac_start, rsp_valid} !== 4'b0100) begin
         miscompares++;
         $display("FAIL b2b_second_beat2: got %b want 0100", {dsp_start, dsp_mac, dsp_mac_start, rsp_valid});
      end
      step();
      vectors++;
      if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 32'h0000_0200}) begin
         miscompares++;
         $display("FAIL b2b_second_resp: got %h want %h", {rsp_valid, rsp_err, rsp_data}, {2'b10, 32'h0000_0200});
      end
      step();
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_mode = 2'd0; req_a = '0; req_b = '0; req_c = '0;
      req_mac = 1'b0; req_shift_amount = 2'd0; req_shift_dir = 1'b0;
      dsp_out = '0; rsp_ready = 1'b1;
      test_reset();
      test_mode0();
      test_mode2();
      test_mode3();
      test_stall();
      test_reset_midflight();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
